// File: rtl/frame_pacer.sv
// frame_pacer: rational-rate frame trigger paced from the PPU pixel clock.
// Optional per-line pulses are built when FRAME_PACER_LINE_EN is defined.
module frame_pacer #(
    parameter int PERIOD_NUM = 179025,
    parameter int PERIOD_DEN = 2,
    parameter int LINES      = 525,
    parameter int LATENCY    = 4,
    parameter int CNT_W      = 18
) (
    input  logic             clk_p,
    input  logic             rst_p,
    input  logic             en,
    input  logic             nudge_req,
    input  logic             nudge_dir,
    output logic             nudge_ack,
    output logic             new_frame,
    output logic             frame_end,
    output logic             frame_long,
    output logic [CNT_W-1:0] pcnt,
    output logic             new_line,
    output logic [9:0]       line_idx
);

    localparam int BASE = PERIOD_NUM / PERIOD_DEN;
    localparam int REM  = PERIOD_NUM % PERIOD_DEN;
    localparam int FAW  = (PERIOD_DEN > 1) ? $clog2(2 * PERIOD_DEN) : 1;

    localparam logic [FAW-1:0]   F_DEN  = FAW'(PERIOD_DEN);
    localparam logic [FAW-1:0]   F_REM  = FAW'(REM);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_BASE = CNT_W'(BASE);
    localparam logic [CNT_W-1:0] C_LAT  = CNT_W'(LATENCY);
    localparam logic             LONG0  = (REM >= PERIOD_DEN);

    if (LATENCY < 1 || LATENCY > BASE - 2 || BASE + 2 >= 2 ** CNT_W ||
        LINES < 1 || LINES > 1024) begin : g_param_err
        $error("frame_pacer: illegal parameter set");
    end

    logic [CNT_W-1:0] pcnt_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_d;
    logic [CNT_W-1:0] blen;
    logic [FAW-1:0]   facc_q;
    logic [FAW-1:0]   facc_d;
    logic [FAW-1:0]   fsum;
    logic             long_q;
    logic             long_d;
    logic             pending_q;
    logic             pdir_q;
    logic             roll;

    // Length of the frame that starts at the coming rollover.
    always_comb begin
        fsum   = facc_q + F_REM;
        facc_d = (fsum >= F_DEN) ? fsum - F_DEN : fsum;
        long_d = ((facc_d + F_REM) >= F_DEN);
        blen   = C_BASE + {{(CNT_W-1){1'b0}}, long_d};
        len_d  = blen;
        if (pending_q) begin
            len_d = pdir_q ? blen + C_ONE : blen - C_ONE;
        end
    end

    assign roll = en && (pcnt_q == len_q - C_ONE);

    always_ff @(posedge clk_p) begin
        if (rst_p) begin
            pcnt_q    <= '0;
            facc_q    <= '0;
            long_q    <= LONG0;
            len_q     <= C_BASE + {{(CNT_W-1){1'b0}}, LONG0};
            pending_q <= 1'b0;
            pdir_q    <= 1'b0;
        end else if (en) begin
            if (roll) begin
                pcnt_q <= '0;
                facc_q <= facc_d;
                long_q <= long_d;
                len_q  <= len_d;
            end else begin
                pcnt_q <= pcnt_q + C_ONE;
            end
            if (!pending_q && nudge_req) begin
                pending_q <= 1'b1;
                pdir_q    <= nudge_dir;
            end else if (pending_q && roll) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign pcnt       = pcnt_q;
    assign frame_end  = roll;
    assign new_frame  = en && (pcnt_q == len_q - C_LAT);
    assign frame_long = long_q;
    assign nudge_ack  = roll && pending_q;

`ifdef FRAME_PACER_LINE_EN
    localparam int DL    = PERIOD_DEN * LINES;
    localparam int LBASE = PERIOD_NUM / DL;
    localparam int LREM  = PERIOD_NUM % DL;
    localparam int LAW   = (DL > 1) ? $clog2(2 * DL) : 1;

    localparam logic [LAW-1:0]   L_DL    = LAW'(DL);
    localparam logic [LAW-1:0]   L_REM   = LAW'(LREM);
    localparam logic [CNT_W-1:0] C_LBASE = CNT_W'(LBASE);
    localparam logic [9:0]       LAST    = 10'(LINES - 1);

    logic [LAW-1:0]   lacc_q;
    logic [LAW-1:0]   lsum;
    logic [CNT_W-1:0] lcnt_q;
    logic [CNT_W-1:0] llen;
    logic [9:0]       lidx_q;
    logic             lextra;
    logic             lbound;

    // The last line has no boundary of its own; rollover closes it.
    always_comb begin
        lsum   = lacc_q + L_REM;
        lextra = (lsum >= L_DL);
        llen   = C_LBASE + {{(CNT_W-1){1'b0}}, lextra};
        lbound = (lcnt_q == llen - C_ONE) && (lidx_q != LAST);
    end

    always_ff @(posedge clk_p) begin
        if (rst_p) begin
            lacc_q <= '0;
            lcnt_q <= '0;
            lidx_q <= '0;
        end else if (en) begin
            if (roll) begin
                lacc_q <= '0;
                lcnt_q <= '0;
                lidx_q <= '0;
            end else if (lbound) begin
                lacc_q <= lextra ? lsum - L_DL : lsum;
                lcnt_q <= '0;
                lidx_q <= lidx_q + 10'd1;
            end else begin
                lcnt_q <= lcnt_q + C_ONE;
            end
        end
    end

    assign new_line = en && (lcnt_q == '0);
    assign line_idx = lidx_q;
`else
    assign new_line = 1'b0;
    assign line_idx = '0;
`endif

endmodule

// File: tb/tb_frame_pacer.sv
// Directed bench for frame_pacer on a scaled-down rate (55/2 cycles per frame).
// Table vectors cover pacing and enable; scans cover nudge, reset and lines.
module tb_frame_pacer;

    localparam int NUM   = 55;
    localparam int DEN   = 2;
    localparam int LINES = 5;
    localparam int LAT   = 4;
    localparam int CW    = 8;

    logic          clk_p = 1'b0;
    logic          rst_p;
    logic          en;
    logic          nudge_req;
    logic          nudge_dir;
    logic          nudge_ack;
    logic          new_frame;
    logic          frame_end;
    logic          frame_long;
    logic [CW-1:0] pcnt;
    logic          new_line;
    logic [9:0]    line_idx;

    frame_pacer #(
        .PERIOD_NUM(NUM),
        .PERIOD_DEN(DEN),
        .LINES     (LINES),
        .LATENCY   (LAT),
        .CNT_W     (CW)
    ) dut (
        .clk_p     (clk_p),
        .rst_p     (rst_p),
        .en        (en),
        .nudge_req (nudge_req),
        .nudge_dir (nudge_dir),
        .nudge_ack (nudge_ack),
        .new_frame (new_frame),
        .frame_end (frame_end),
        .frame_long(frame_long),
        .pcnt      (pcnt),
        .new_line  (new_line),
        .line_idx  (line_idx)
    );

    always #5 clk_p = ~clk_p;

    typedef struct {
        bit    rst;
        bit    en;
        bit    req;
        bit    dir;
        int    hold;
        int    pcnt;
        bit    nf;
        bit    fe;
        bit    fl;
        bit    ack;
        string nm;
    } vec_t;

    vec_t tab[$];
    int   total = 0;
    int   bad   = 0;

    int ack_c[$];
    int fe_c[$];
    int nl_pc[$];
    int li_fe[$];
    int li_st[$];
    int pc_after;
    int nl_cnt;
    int li_nz;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_p);
        #1;
    endtask

    task automatic do_reset();
        rst_p     = 1'b1;
        en        = 1'b0;
        nudge_req = 1'b0;
        nudge_dir = 1'b0;
        tick();
        tick();
        rst_p = 1'b0;
        en    = 1'b1;
    endtask

    // Cycle c counts from the first enabled cycle after reset (pcnt = 0).
    task automatic scan(input int n, input int rq_from, input int rq_to,
                        input bit dir, input int rst_at);
        bit acked = 1'b0;
        ack_c.delete();
        fe_c.delete();
        nl_pc.delete();
        li_fe.delete();
        li_st.delete();
        pc_after = -1;
        nl_cnt   = 0;
        li_nz    = 0;
        for (int c = 0; c < n; c++) begin
            nudge_req = (c >= rq_from) && (c < rq_to) && !acked;
            nudge_dir = dir;
            rst_p     = (c == rst_at);
            #1;
            if (nudge_ack) ack_c.push_back(c);
            if (frame_end) begin
                fe_c.push_back(c);
                li_fe.push_back(int'(line_idx));
            end
            if (new_line) begin
                nl_cnt++;
                if (c < NUM / DEN) nl_pc.push_back(int'(pcnt));
            end
            if (line_idx != 10'd0) li_nz++;
            if (c > 0 && pcnt == '0) li_st.push_back(int'(line_idx));
            if (c == rst_at + 1) pc_after = int'(pcnt);
            if (nudge_ack) acked = 1'b1;
            tick();
        end
        nudge_req = 1'b0;
        rst_p     = 1'b0;
    endtask

    initial begin
        rst_p     = 1'b1;
        en        = 1'b0;
        nudge_req = 1'b0;
        nudge_dir = 1'b0;

        // rst en req dir hold | pcnt nf fe fl ack
        tab.push_back('{1, 0, 0, 0,  2,  0, 0, 0, 0, 0, "reset"});
        tab.push_back('{0, 1, 0, 0,  0,  0, 0, 0, 0, 0, "cycle0"});
        tab.push_back('{0, 1, 0, 0, 23, 23, 1, 0, 0, 0, "nf_f0"});
        tab.push_back('{0, 1, 0, 0,  1, 24, 0, 0, 0, 0, "nf_one_cycle"});
        tab.push_back('{0, 1, 0, 0,  2, 26, 0, 1, 0, 0, "fe_f0"});
        tab.push_back('{0, 1, 0, 0,  1,  0, 0, 0, 1, 0, "f1_start"});
        tab.push_back('{0, 1, 0, 0, 24, 24, 1, 0, 1, 0, "nf_f1"});
        tab.push_back('{0, 1, 0, 0,  3, 27, 0, 1, 1, 0, "fe_f1"});
        tab.push_back('{0, 1, 0, 0,  1,  0, 0, 0, 0, 0, "f2_start"});
        tab.push_back('{0, 1, 0, 0, 20, 20, 0, 0, 0, 0, "pre_stall"});
        tab.push_back('{0, 0, 0, 0,  0, 20, 0, 0, 0, 0, "stall_enter"});
        tab.push_back('{0, 0, 1, 1,  5, 20, 0, 0, 0, 0, "stall_hold"});
        tab.push_back('{0, 1, 0, 0,  0, 20, 0, 0, 0, 0, "resume"});
        tab.push_back('{0, 1, 0, 0,  3, 23, 1, 0, 0, 0, "nf_f2"});
        tab.push_back('{0, 0, 0, 0,  0, 23, 0, 0, 0, 0, "nf_gated"});
        tab.push_back('{0, 1, 0, 0,  0, 23, 1, 0, 0, 0, "nf_ungated"});
        tab.push_back('{0, 1, 0, 0,  3, 26, 0, 1, 0, 0, "fe_f2_no_nudge"});
        tab.push_back('{0, 1, 0, 0,  1,  0, 0, 0, 1, 0, "f3_start"});

        foreach (tab[i]) begin
            rst_p     = tab[i].rst;
            en        = tab[i].en;
            nudge_req = tab[i].req;
            nudge_dir = tab[i].dir;
            repeat (tab[i].hold) tick();
            #1;
            chk({tab[i].nm, ".pcnt"}, int'(pcnt), tab[i].pcnt);
            chk({tab[i].nm, ".new_frame"}, int'(new_frame), int'(tab[i].nf));
            chk({tab[i].nm, ".frame_end"}, int'(frame_end), int'(tab[i].fe));
            chk({tab[i].nm, ".frame_long"}, int'(frame_long), int'(tab[i].fl));
            chk({tab[i].nm, ".nudge_ack"}, int'(nudge_ack), int'(tab[i].ack));
        end
        tick();

        // Lengthening nudge requested mid-frame 0.
        do_reset();
        scan(100, 10, 1000, 1'b1, -1);
        chk("nudge_up.acks", ack_c.size(), 1);
        chk("nudge_up.ack_cycle", ack_c[0], 26);
        chk("nudge_up.fe0", fe_c[0], 26);
        chk("nudge_up.fe1", fe_c[1], 55);
        chk("nudge_up.fe2", fe_c[2], 82);

        // Shortening nudge raised in the rollover cycle itself.
        do_reset();
        scan(120, 26, 1000, 1'b0, -1);
        chk("nudge_dn.acks", ack_c.size(), 1);
        chk("nudge_dn.ack_cycle", ack_c[0], 54);
        chk("nudge_dn.fe1", fe_c[1], 54);
        chk("nudge_dn.fe2", fe_c[2], 80);
        chk("nudge_dn.fe3", fe_c[3], 108);

        // Reset mid-frame discards a pending nudge.
        do_reset();
        scan(80, 5, 15, 1'b1, 15);
        chk("rst_mid.acks", ack_c.size(), 0);
        chk("rst_mid.pcnt_after", pc_after, 0);
        chk("rst_mid.fe0", fe_c[0], 42);
        chk("rst_mid.fe1", fe_c[1], 70);

        // Line pulses.
        do_reset();
        scan(60, 1000, 1000, 1'b0, -1);
`ifdef FRAME_PACER_LINE_EN
        chk("line.count_f0", nl_pc.size(), 5);
        chk("line.nl0", nl_pc[0], 0);
        chk("line.nl1", nl_pc[1], 5);
        chk("line.nl2", nl_pc[2], 11);
        chk("line.nl3", nl_pc[3], 16);
        chk("line.nl4", nl_pc[4], 22);
        chk("line.idx_at_fe", li_fe[0], LINES - 1);
        chk("line.idx_next_frame", li_st[0], 0);
`else
        chk("line.no_pulses", nl_cnt, 0);
        chk("line.idx_zero", li_nz, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_pacer.md
# frame_pacer

Parametrised frame/line trigger for the NES→HDMI path, clocked by the PPU pixel clock. It paces output frames at a rational number of input cycles per frame using a fractional accumulator, so an arbitrary output-to-PPU rate ratio produces a bounded-jitter sequence of frame lengths. It raises `new_frame` a fixed number of cycles before each rollover. It adds a count enable, a request/acknowledge phase-nudge port for drift correction, and optional per-line pulses.

## Interface
- `PERIOD_NUM`, 179025 (525·341): numerator of input cycles per output frame.
- `PERIOD_DEN`, 2: denominator of input cycles per output frame.
- `LINES`, 525: output lines per frame (line feature only).
- `LATENCY`, 4: `new_frame` leads frame rollover by this many cycles. Legal range is 1..BASE−2.
- `CNT_W`, 18: cycle counter width. Requires BASE+2 < 2^CNT_W.
- Derived values: BASE = ⌊NUM/DEN⌋, REM = NUM mod DEN, LBASE = ⌊NUM/(DEN·LINES)⌋, LREM = NUM mod (DEN·LINES).

Ports:
- `clk_p` in 1: PPU pixel clock.
- `rst_p` in 1: synchronous, active-high reset in the `clk_p` domain.
- `en` in 1: count enable. When low, all state holds and all pulses are suppressed.
- `nudge_req` in 1: phase-nudge request, level. Hold it high until `nudge_ack`.
- `nudge_dir` in 1: 1 lengthens the next frame by 1 cycle; 0 shortens it by 1 cycle.
- `nudge_ack` out 1: one-cycle pulse when the nudge is applied.
- `new_frame` out 1: one-cycle pulse at pcnt == LEN−LATENCY.
- `frame_end` out 1: one-cycle pulse at pcnt == LEN−1 (the rollover cycle).
- `frame_long` out 1: the current frame's LEN includes the +1 from the accumulator.
- `pcnt` out CNT_W: cycle index within the current frame.
- `new_line` out 1: line-start pulse. Only with `FRAME_PACER_LINE_EN`.
- `line_idx` out 10: current line index. Only with `FRAME_PACER_LINE_EN`.

## Operation
- State: `pcnt`, frame accumulator `facc` (0..DEN−1), current length `LEN`, nudge `pending`/`pdir`.
- Frame length: LEN = BASE + long + nudge, where long = (facc+REM ≥ DEN) evaluated at frame start, and nudge ∈ {−1, 0, +1}.
- At rollover (en && pcnt == LEN−1):
  - pcnt ← 0.
  - facc ← (facc+REM) mod DEN.
  - The next LEN is computed from the new facc.
- Nudge handshake:
  - When `pending` = 0 and `nudge_req` = 1, latch `pdir` and set `pending`.
  - At the next rollover, the pending nudge is applied to the frame that starts there. `nudge_ack` pulses in that rollover cycle and `pending` clears.
  - `nudge_req` while `pending` = 1 is ignored.
  - A request that arrives in the rollover cycle while `pending` = 0 is latched and applied at the following rollover.
  - The requester drops `nudge_req` in the cycle after `nudge_ack`. If it is still high, a new request is latched.
- Decoding: `new_frame`, `frame_end`, `new_line` are decoded from registered state, qualified by `en`.

## Timing
- Reset values:
  - pcnt = 0, facc = 0, pending = 0, `nudge_ack` = 0, line_idx = 0.
  - The LEN of frame 0 is computed from facc = 0.
- On the first enabled cycle after reset, pcnt = 0. Frame 0 `new_frame` occurs at cycle BASE+long−LATENCY.
- `en` low: pcnt, facc, line state, and `pending` all freeze. A request cannot be latched while `en` is low.
- Reset mid-frame: everything returns to reset values. A pending nudge is discarded without an ack.
- With the default parameters, frames alternate 89512, 89513, 89512, … and `frame_long` = 0, 1, 0, ….

## Configuration
- `FRAME_PACER_LINE_EN` defined:
  - A line counter and line accumulator `lacc` run.
  - `new_line` pulses at pcnt 0 and at every line boundary. Line length is LBASE + (lacc+LREM ≥ DEN·LINES).
  - `line_idx` increments at each boundary and saturates at LINES−1; the last line is truncated or extended by frame rollover.
  - `lacc` and `line_idx` reset to 0 at every frame rollover.
  - Default line lengths are 170, 171, 170, ….
- `FRAME_PACER_LINE_EN` undefined: `new_line` = 0 and `line_idx` = 0, and no line logic is present.

## Test plan
- Reset, defaults, `en` = 1:
  - `new_frame` at cycles 89508 and 179021.
  - `frame_end` at 89511 and 179024.
  - `frame_long` 0 then 1.
- `nudge_req` = 1, `nudge_dir` = 1 at cycle 1000:
  - `nudge_ack` at cycle 89511.
  - Frame 1 is 89514 cycles.
  - Frame 2 reverts to 89512.
- `nudge_dir` = 0, request issued in the rollover cycle 89511:
  - Not acked at 89511.
  - Acked at 179024.
  - Frame 2 is 89511 cycles.
- `en` low for 100 cycles starting at pcnt = 89500:
  - `new_frame` shifts to cycle 89608.
  - pcnt holds at 89500 throughout the stall.
- `rst_p` pulse at pcnt = 50000 with a nudge pending:
  - pcnt = 0, no ack.
  - The next `frame_end` is 89512 cycles after release.
- With `FRAME_PACER_LINE_EN`:
  - `new_line` at pcnt 0, 170, 341, 511.
  - `line_idx` = 524 at the rollover.
  - `line_idx` = 0 on the next frame.
